// File: rtl/inst_rom_loader.sv
// Instruction ROM on the CPU fetch port with a byte-serial loader that fills the
// array at run time, holding the CPU in reset until the load has been flushed.
module inst_rom_loader #(
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rom_ce_i,
    input  logic [31:0]           rom_addr_i,
    output logic [31:0]           rom_data_o,
    input  logic                  ld_start_i,
    input  logic [ADDR_WIDTH:0]   ld_len_i,
    input  logic [7:0]            ld_byte_i,
    input  logic                  ld_valid_i,
    output logic                  ld_ready_o,
    output logic                  cpu_rst_o,
    output logic                  ld_busy_o,
    output logic                  ld_err_o
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] ONE_L   = (ADDR_WIDTH + 1)'(1);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_LOAD  = 2'd1,
        ST_FLUSH = 2'd2
    } state_e;

    state_e                state_q, state_d;
    logic [1:0]            byte_cnt_q, byte_cnt_d;
    logic [ADDR_WIDTH-1:0] word_ptr_q, word_ptr_d;
    logic [ADDR_WIDTH:0]   words_left_q, words_left_d;
    logic [23:0]           asm_q, asm_d;
    logic                  err_q, err_d;
    logic                  cpu_rst_q, cpu_rst_d;
    logic                  ready_q, ready_d;
    logic                  busy_q, busy_d;
    logic                  we_s;
    logic [31:0]           wdata_s;
    logic [31:0]           mem_q [DEPTH];
    logic                  unused_addr_s;

    assign unused_addr_s = ^{rom_addr_i[31:ADDR_WIDTH+2], rom_addr_i[1:0]};

    // State and counter registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_RUN;
            byte_cnt_q   <= 2'd0;
            word_ptr_q   <= '0;
            words_left_q <= '0;
            asm_q        <= 24'h0;
            err_q        <= 1'b0;
            cpu_rst_q    <= 1'b0;
            ready_q      <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            byte_cnt_q   <= byte_cnt_d;
            word_ptr_q   <= word_ptr_d;
            words_left_q <= words_left_d;
            asm_q        <= asm_d;
            err_q        <= err_d;
            cpu_rst_q    <= cpu_rst_d;
            ready_q      <= ready_d;
            busy_q       <= busy_d;
        end
    end

    // Next-state, byte assembly and write-port control
    always_comb begin
        state_d      = state_q;
        byte_cnt_d   = byte_cnt_q;
        word_ptr_d   = word_ptr_q;
        words_left_d = words_left_q;
        asm_d        = asm_q;
        err_d        = err_q;
        we_s         = 1'b0;
        wdata_s      = 32'h0;
        case (state_q)
            ST_RUN: begin
                if (ld_start_i) begin
                    word_ptr_d = '0;
                    byte_cnt_d = 2'd0;
                    if (ld_len_i > DEPTH_L) begin
                        words_left_d = DEPTH_L;
                        err_d        = 1'b1;
                    end else begin
                        words_left_d = ld_len_i;
                        err_d        = 1'b0;
                    end
                    state_d = (ld_len_i == '0) ? ST_FLUSH : ST_LOAD;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_LOAD: begin
                // Big-endian assembly: the fourth byte completes the word and is written directly
                if (ld_valid_i && ready_q) begin
                    asm_d      = {asm_q[15:0], ld_byte_i};
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) begin
                        we_s         = 1'b1;
                        wdata_s      = {asm_q, ld_byte_i};
                        word_ptr_d   = word_ptr_q + ADDR_WIDTH'(1);
                        words_left_d = words_left_q - ONE_L;
                        if (words_left_q == ONE_L) begin
                            state_d = ST_FLUSH;
                        end else begin
                            state_d = ST_LOAD;
                        end
                    end else begin
                        state_d = ST_LOAD;
                    end
                end else begin
                    state_d = ST_LOAD;
                end
            end
            ST_FLUSH: begin
                state_d = ST_RUN;
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
        cpu_rst_d = (state_d != ST_RUN);
        busy_d    = (state_d != ST_RUN);
        ready_d   = (state_d == ST_LOAD);
    end

    // Instruction array write port; contents deliberately survive reset
    always_ff @(posedge clk) begin
        if (we_s) begin
            mem_q[word_ptr_q] <= wdata_s;
        end
    end

    // Zero-latency fetch; NOP while the loader owns the array
    always_comb begin
        rom_data_o = 32'h0;
        if (rom_ce_i && (state_q == ST_RUN)) begin
            rom_data_o = mem_q[rom_addr_i[ADDR_WIDTH+1:2]];
        end else begin
            rom_data_o = 32'h0;
        end
    end

    assign ld_ready_o = ready_q;
    assign cpu_rst_o  = cpu_rst_q;
    assign ld_busy_o  = busy_q;
    assign ld_err_o   = err_q;

endmodule

// File: tb/tb_inst_rom_loader.sv
// Randomized bench for inst_rom_loader: a word-array model is built from the byte
// stream (four bytes per word, first byte most significant) and compared via fetches.
module tb_inst_rom_loader;
    localparam int AW    = 10;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          rom_ce_i = 1'b0;
    logic [31:0]   rom_addr_i = 32'h0;
    logic [31:0]   rom_data_o;
    logic          ld_start_i = 1'b0;
    logic [AW:0]   ld_len_i = '0;
    logic [7:0]    ld_byte_i = 8'h0;
    logic          ld_valid_i = 1'b0;
    logic          ld_ready_o, cpu_rst_o, ld_busy_o, ld_err_o;

    int            total = 0;
    int            bad = 0;
    logic [31:0]   ref_mem [DEPTH];
    bit            known [DEPTH];
    logic [7:0]    bq [$];
    bit            timed_out;

    inst_rom_loader #(.ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst(rst), .rom_ce_i(rom_ce_i), .rom_addr_i(rom_addr_i),
        .rom_data_o(rom_data_o), .ld_start_i(ld_start_i), .ld_len_i(ld_len_i),
        .ld_byte_i(ld_byte_i), .ld_valid_i(ld_valid_i), .ld_ready_o(ld_ready_o),
        .cpu_rst_o(cpu_rst_o), .ld_busy_o(ld_busy_o), .ld_err_o(ld_err_o)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_load(input logic [AW:0] len);
        ld_start_i = 1'b1;
        ld_len_i   = len;
        tick();
        ld_start_i = 1'b0;
    endtask

    task automatic send_bytes(input bit gaps, input bit pulse_start);
        int  idx = 0;
        int  guard = 0;
        bit  phase = 1'b0;
        timed_out = 1'b0;
        while (idx < bq.size()) begin
            if (guard > 4 * bq.size() + 100) begin
                timed_out = 1'b1;
                break;
            end
            guard++;
            phase      = gaps ? ~phase : 1'b1;
            ld_valid_i = phase;
            ld_byte_i  = phase ? bq[idx] : 8'($urandom);
            ld_start_i = pulse_start ? 1'($urandom) : 1'b0;
            ld_len_i   = (AW + 1)'($urandom);
            if (phase && ld_ready_o) idx++;
            tick();
        end
        ld_valid_i = 1'b0;
        ld_start_i = 1'b0;
    endtask

    task automatic fill_random(input int n);
        bq.delete();
        for (int i = 0; i < n; i++) bq.push_back(8'($urandom));
    endtask

    task automatic model_commit(input int nwords);
        for (int i = 0; i < nwords; i++) begin
            ref_mem[i] = {bq[4*i], bq[4*i+1], bq[4*i+2], bq[4*i+3]};
            known[i]   = 1'b1;
        end
    endtask

    task automatic fetch(input logic [31:0] addr, output logic [31:0] d);
        rom_ce_i   = 1'b1;
        rom_addr_i = addr;
        #1;
        d = rom_data_o;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        rst = 1'b1;
        #2;
        total++; if (cpu_rst_o !== 1'b0) begin bad++; $display("FAIL reset_cpu_rst got=%0b exp=0", cpu_rst_o); end
        total++; if (ld_ready_o !== 1'b0) begin bad++; $display("FAIL reset_ready got=%0b exp=0", ld_ready_o); end
        total++; if (ld_busy_o !== 1'b0) begin bad++; $display("FAIL reset_busy got=%0b exp=0", ld_busy_o); end
        total++; if (ld_err_o !== 1'b0) begin bad++; $display("FAIL reset_err got=%0b exp=0", ld_err_o); end
        rom_ce_i = 1'b0;
        #1;
        d = rom_data_o;
        total++; if (d !== 32'h0) begin bad++; $display("FAIL reset_ce0 got=%h exp=0", d); end
        tick(); tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_load_basic();
        logic [31:0] d;
        bq = '{8'h34, 8'h01, 8'hFF, 8'h00, 8'h34, 8'h02, 8'h00, 8'h0F};
        start_load(11'd2);
        total++; if ({cpu_rst_o, ld_busy_o, ld_ready_o} !== 3'b111) begin bad++; $display("FAIL load_enter got=%b exp=111", {cpu_rst_o, ld_busy_o, ld_ready_o}); end
        send_bytes(1'b0, 1'b0);
        total++; if (timed_out !== 1'b0) begin bad++; $display("FAIL load_timeout got=%0b exp=0", timed_out); end
        total++; if ({cpu_rst_o, ld_busy_o, ld_ready_o} !== 3'b110) begin bad++; $display("FAIL load_flush got=%b exp=110", {cpu_rst_o, ld_busy_o, ld_ready_o}); end
        fetch(32'h0, d);
        total++; if (d !== 32'h0) begin bad++; $display("FAIL flush_nop got=%h exp=0", d); end
        tick();
        total++; if ({cpu_rst_o, ld_busy_o, ld_ready_o} !== 3'b000) begin bad++; $display("FAIL load_exit got=%b exp=000", {cpu_rst_o, ld_busy_o, ld_ready_o}); end
        model_commit(2);
        fetch(32'h0, d);
        total++; if (d !== 32'h3401_FF00) begin bad++; $display("FAIL load_word0 got=%h exp=3401ff00", d); end
        fetch(32'h4, d);
        total++; if (d !== 32'h3402_000F) begin bad++; $display("FAIL load_word1 got=%h exp=3402000f", d); end
    endtask

    task automatic test_fetch();
        logic [31:0] d;
        fetch(32'h7, d);
        total++; if (d !== ref_mem[1]) begin bad++; $display("FAIL fetch_lowbits got=%h exp=%h", d, ref_mem[1]); end
        fetch(32'h4 + 32'(DEPTH * 4), d);
        total++; if (d !== ref_mem[1]) begin bad++; $display("FAIL fetch_alias got=%h exp=%h", d, ref_mem[1]); end
        rom_ce_i = 1'b0;
        #1;
        d = rom_data_o;
        total++; if (d !== 32'h0) begin bad++; $display("FAIL fetch_ce0 got=%h exp=0", d); end
    endtask

    task automatic test_load(input int len, input bit gaps, input bit pulse_start);
        logic [31:0] d;
        fill_random(4 * len);
        start_load((AW + 1)'(len));
        send_bytes(gaps, pulse_start);
        total++; if (timed_out !== 1'b0) begin bad++; $display("FAIL load%0d_timeout got=%0b exp=0", len, timed_out); end
        total++; if (ld_busy_o !== 1'b1 || ld_ready_o !== 1'b0) begin bad++; $display("FAIL load%0d_flush busy=%0b ready=%0b exp busy=1 ready=0", len, ld_busy_o, ld_ready_o); end
        tick();
        model_commit(len);
        for (int i = 0; i < 8; i++) begin
            if (known[i]) begin
                fetch(32'(i * 4), d);
                total++; if (d !== ref_mem[i]) begin bad++; $display("FAIL load%0d_word%0d got=%h exp=%h", len, i, d, ref_mem[i]); end
            end
        end
    endtask

    task automatic test_zero_len();
        logic [31:0] d;
        start_load(11'd0);
        total++; if ({cpu_rst_o, ld_busy_o, ld_ready_o} !== 3'b110) begin bad++; $display("FAIL zero_flush got=%b exp=110", {cpu_rst_o, ld_busy_o, ld_ready_o}); end
        tick();
        total++; if ({cpu_rst_o, ld_busy_o, ld_ready_o} !== 3'b000) begin bad++; $display("FAIL zero_run got=%b exp=000", {cpu_rst_o, ld_busy_o, ld_ready_o}); end
        for (int i = 0; i < 4; i++) begin
            fetch(32'(i * 4), d);
            total++; if (d !== ref_mem[i]) begin bad++; $display("FAIL zero_word%0d got=%h exp=%h", i, d, ref_mem[i]); end
        end
    endtask

    task automatic test_overlength();
        logic [31:0] d;
        int          idx;
        fill_random(4 * DEPTH);
        start_load((AW + 1)'(DEPTH + 5));
        total++; if (ld_err_o !== 1'b1) begin bad++; $display("FAIL over_err got=%0b exp=1", ld_err_o); end
        send_bytes(1'b0, 1'b0);
        total++; if (timed_out !== 1'b0 || ld_ready_o !== 1'b0 || ld_busy_o !== 1'b1) begin bad++; $display("FAIL over_flush to=%0b ready=%0b busy=%0b exp 0 0 1", timed_out, ld_ready_o, ld_busy_o); end
        tick();
        total++; if (ld_busy_o !== 1'b0 || ld_err_o !== 1'b1) begin bad++; $display("FAIL over_run busy=%0b err=%0b exp busy=0 err=1", ld_busy_o, ld_err_o); end
        model_commit(DEPTH);
        for (int k = 0; k < 18; k++) begin
            idx = (k == 0) ? 0 : (k == 1) ? DEPTH - 1 : $urandom_range(0, DEPTH - 1);
            fetch(32'(idx * 4), d);
            total++; if (d !== ref_mem[idx]) begin bad++; $display("FAIL over_word%0d got=%h exp=%h", idx, d, ref_mem[idx]); end
        end
        fill_random(4);
        start_load(11'd1);
        total++; if (ld_err_o !== 1'b0) begin bad++; $display("FAIL err_clear got=%0b exp=0", ld_err_o); end
        send_bytes(1'b0, 1'b0);
        tick();
        model_commit(1);
        fetch(32'h0, d);
        total++; if (d !== ref_mem[0]) begin bad++; $display("FAIL len1_word0 got=%h exp=%h", d, ref_mem[0]); end
    endtask

    task automatic test_reset_midload();
        logic [31:0] d;
        fill_random(6);
        start_load(11'd2);
        send_bytes(1'b0, 1'b0);
        total++; if (ld_ready_o !== 1'b1) begin bad++; $display("FAIL mid_still_loading got=%0b exp=1", ld_ready_o); end
        #2;
        rst = 1'b1;
        #1;
        total++; if ({cpu_rst_o, ld_busy_o, ld_ready_o} !== 3'b000) begin bad++; $display("FAIL mid_async got=%b exp=000", {cpu_rst_o, ld_busy_o, ld_ready_o}); end
        model_commit(1);
        tick();
        rst = 1'b0;
        tick();
        fetch(32'h0, d);
        total++; if (d !== ref_mem[0]) begin bad++; $display("FAIL mid_word0 got=%h exp=%h", d, ref_mem[0]); end
        fetch(32'h4, d);
        total++; if (d !== ref_mem[1]) begin bad++; $display("FAIL mid_word1 got=%h exp=%h", d, ref_mem[1]); end
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            known[i]   = 1'b0;
            ref_mem[i] = 32'h0;
        end
        #1;
        test_reset();
        test_load_basic();
        test_fetch();
        test_load(3, 1'b1, 1'b0);
        for (int r = 0; r < 4; r++) begin
            test_load($urandom_range(1, 6), 1'($urandom), 1'b1);
        end
        test_zero_len();
        test_overlength();
        test_reset_midload();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
